// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO that launches queued words into a UART transmitter one at a time.
// Optional UART_FEED_TIMEOUT_EN abandons a byte whose tx_done never arrives.
module uart_tx_feeder #(
    parameter int DATA_W         = 8,
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_done,
`ifdef UART_FEED_TIMEOUT_EN
    output logic                    timeout_err,
`endif
    output logic                    busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("uart_tx_feeder: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level_nxt;
    logic              push, pop;
    state_t            state;

    // full is the registered flag, so a push while full loses even if a pop frees a slot
    assign push      = wr_en && !full;
    assign pop       = state == IDLE && !empty;
    assign level_nxt = level + LW'(push) - LW'(pop);
    assign busy      = state != IDLE;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wr_data;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(push);
            rd_ptr   <= rd_ptr + AW'(pop);
            level    <= level_nxt;
            full     <= level_nxt == LW'(DEPTH);
            empty    <= level_nxt == '0;
            overflow <= wr_en && full;
        end

`ifdef UART_FEED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
`endif

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
`ifdef UART_FEED_TIMEOUT_EN
            to_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx_start <= !empty;
                    if (!empty) begin
                        tx_data <= mem[rd_ptr];
                        state   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tx_start <= 1'b0;
                    state    <= WAIT_DONE;
`ifdef UART_FEED_TIMEOUT_EN
                    to_cnt   <= '0;
`endif
                end
                WAIT_DONE: begin
                    tx_start <= 1'b0;
                    if (tx_done) state <= IDLE;
`ifdef UART_FEED_TIMEOUT_EN
                    // the edge that completes the TIMEOUT_CYCLES-th silent cycle gives up
                    else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                    end else to_cnt <= to_cnt + 1'b1;
`endif
                end
                default: begin
                    tx_start <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed bench with a launch-order scoreboard for uart_tx_feeder.
// Define UART_FEED_TIMEOUT_EN to also exercise the timeout path (TIMEOUT_CYCLES=50).
module tb_uart_tx_feeder;
    logic       clk = 1'b0, rst = 1'b0, wr_en = 1'b0, tx_done = 1'b0;
    logic [7:0] wr_data = '0;
    logic       full, empty, overflow, tx_start, busy;
    logic [4:0] level;
    logic [7:0] tx_data;
`ifdef UART_FEED_TIMEOUT_EN
    logic       timeout_err;
`endif
    int         total = 0, passed = 0, fails = 0, launches = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_tx_feeder #(.DATA_W(8), .DEPTH(16), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .level(level), .overflow(overflow),
        .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
`ifdef UART_FEED_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        exp_q.push_back(b);
        tick;
        wr_en   = 1'b0;
    endtask

    task automatic wait_launch(output int waited);
        waited = 0;
        while (tx_start !== 1'b1 && waited < 40) begin
            tick;
            waited++;
        end
        chk("launch_seen", 32'(tx_start), 1);
        tick;
        chk("start_one_cycle", 32'(tx_start), 0);
    endtask

    task automatic drain(input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            repeat (2) tick;
            chk("busy_waiting", 32'(busy), 1);
            tx_done = 1'b1;
            tick;
            tx_done = 1'b0;
            chk("idle_after_done", 32'(busy), 0);
            chk("no_start_at_done", 32'(tx_start), 0);
            if (i < n - 1) begin
                wait_launch(w);
                chk("done_to_start_gap", 32'(w), 1);
            end
        end
    endtask

    // scoreboard: every launch must match the oldest accepted push
    always @(negedge clk)
        if (rst && tx_start) begin
            launches++;
            chk("sb_has_entry", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("tx_data_order", 32'(tx_data), 32'(exp_q.pop_front()));
        end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w, n, l0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", 32'(level), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
`ifdef UART_FEED_TIMEOUT_EN
        chk("rst_timeout_err", 32'(timeout_err), 0);
`endif
        rst = 1'b1;
        tick;

        // single byte latency
        push(8'hA5);
        chk("single_level", 32'(level), 1);
        chk("single_not_empty", 32'(empty), 0);
        chk("single_no_start_yet", 32'(tx_start), 0);
        wait_launch(w);
        chk("single_latency", 32'(w), 1);
        chk("single_data", 32'(tx_data), 32'hA5);
        chk("single_level_popped", 32'(level), 0);
        repeat (5) tick;
        chk("single_busy_held", 32'(busy), 1);
        drain(1);
        tick;
        chk("single_data_held", 32'(tx_data), 32'hA5);
        chk("single_no_relaunch", 32'(tx_start), 0);

        // burst of 16 back-to-back pushes; the first is popped while the rest arrive
        for (int i = 1; i <= 16; i++) push(8'(i));
        chk("burst_level", 32'(level), 15);
        chk("burst_not_full", 32'(full), 0);
        drain(16);
        chk("burst_empty", 32'(empty), 1);
        chk("burst_sb_empty", 32'(exp_q.size()), 0);

        // overflow while the FSM is stuck waiting
        push(8'h20);
        wait_launch(w);
        for (int i = 0; i < 16; i++) push(8'h30 + 8'(i));
        chk("ovf_full", 32'(full), 1);
        chk("ovf_level16", 32'(level), 16);
        chk("ovf_no_pulse_yet", 32'(overflow), 0);
        wr_en   = 1'b1;
        wr_data = 8'hFF;
        tick;
        wr_en   = 1'b0;
        chk("ovf_pulse", 32'(overflow), 1);
        chk("ovf_level_kept", 32'(level), 16);
        tick;
        chk("ovf_pulse_one_cycle", 32'(overflow), 0);
        drain(17);
        chk("ovf_sb_empty", 32'(exp_q.size()), 0);
        chk("ovf_empty", 32'(empty), 1);

        // push on the same edge as a pop at level 5
        for (int i = 0; i < 6; i++) push(8'h50 + 8'(i));
        chk("sim_level5", 32'(level), 5);
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
        chk("sim_idle", 32'(busy), 0);
        wr_en   = 1'b1;
        wr_data = 8'h56;
        exp_q.push_back(8'h56);
        tick;
        wr_en   = 1'b0;
        chk("sim_level_unchanged", 32'(level), 5);
        chk("sim_launch", 32'(tx_start), 1);
        tick;
        drain(6);
        chk("sim_sb_empty", 32'(exp_q.size()), 0);

        // asynchronous reset mid WAIT_DONE
        for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
        tick;
        chk("rst2_level3", 32'(level), 3);
        chk("rst2_busy", 32'(busy), 1);
        #2 rst = 1'b0;
        #1;
        chk("rst2_level", 32'(level), 0);
        chk("rst2_empty", 32'(empty), 1);
        chk("rst2_full", 32'(full), 0);
        chk("rst2_busy_clear", 32'(busy), 0);
        chk("rst2_tx_start", 32'(tx_start), 0);
        chk("rst2_tx_data", 32'(tx_data), 0);
        chk("rst2_overflow", 32'(overflow), 0);
        exp_q.delete();
        tick;
        #2 rst = 1'b1;
        l0 = launches;
        repeat (6) tick;
        chk("rst2_no_launch", 32'(launches - l0), 0);
        chk("rst2_still_empty", 32'(empty), 1);
        push(8'h77);
        wait_launch(w);
        chk("rst2_recover_latency", 32'(w), 1);
        drain(1);

`ifdef UART_FEED_TIMEOUT_EN
        push(8'h81);
        push(8'h82);
        chk("to_launch", 32'(tx_start), 1);
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick;
            n++;
        end
        chk("to_cycles", 32'(n), 51);
        chk("to_err_set", 32'(timeout_err), 1);
        wait_launch(w);
        chk("to_next_launch", 32'(w), 1);
        drain(1);
        chk("to_err_sticky", 32'(timeout_err), 1);
        chk("to_sb_empty", 32'(exp_q.size()), 0);
`else
        n = 0;
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
